// File: rtl/reg_read.sv
// reg_read: register-read stage holding the integer/float register files and busy-bit scoreboard.
// Optional macro REG_READ_BYPASS_EN forwards in-flight write-back data and readiness.
module reg_read (
  input  logic        clk,
  input  logic        rst,
  input  logic        enabled,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        rs1_is_f,
  input  logic        rs2_is_f,
  input  logic [4:0]  rs3,
  input  logic        uses_rs1,
  input  logic        uses_rs2,
  input  logic        uses_rs3,
  input  logic [4:0]  rd,
  input  logic        writes_to_reg,
  input  logic        writes_to_freg,
  input  logic        reg_w_enable,
  input  logic        freg_w_enable,
  input  logic [4:0]  reg_w_dest,
  input  logic [31:0] reg_w_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] rs3_data,
  output logic        completed
);

  typedef enum logic {StIdle, StWait} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_xreg [32];
  logic [31:0] r_freg [32];
  logic [31:0] r_xbusy, r_fbusy, w_xbusy_d, w_fbusy_d;
  logic [4:0]  r_src [3];
  logic [2:0]  r_src_f, r_uses;
  logic [4:0]  r_rd;
  logic        r_wr_x, r_wr_f, r_done;
  logic [31:0] r_data [3];
  logic [31:0] w_val [3];
  logic [2:0]  w_ready;
  logic        w_fire, w_x_wr;

  // x0 is hardwired: its write-back is dropped entirely.
  assign w_x_wr = reg_w_enable && (reg_w_dest != 5'd0);

  always_comb begin
    w_ready = '0;
    for (int k = 0; k < 3; k++) begin
      w_val[k]   = r_src_f[k] ? r_freg[r_src[k]]
                              : ((r_src[k] == 5'd0) ? 32'd0 : r_xreg[r_src[k]]);
      w_ready[k] = !r_uses[k] || !(r_src_f[k] ? r_fbusy[r_src[k]] : r_xbusy[r_src[k]]);
`ifdef REG_READ_BYPASS_EN
      if ((r_src_f[k] ? freg_w_enable : w_x_wr) && (reg_w_dest == r_src[k])) begin
        w_val[k]   = reg_w_data;
        w_ready[k] = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_fire    = 1'b0;
    case (r_state)
      StIdle: if (enabled) w_state_d = StWait;
      StWait: begin
        if (&w_ready) begin
          w_fire    = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Reservation is applied after the clear so that a same-cycle reserve wins.
  always_comb begin
    w_xbusy_d = r_xbusy;
    w_fbusy_d = r_fbusy;
    if (w_x_wr)            w_xbusy_d[reg_w_dest] = 1'b0;
    if (freg_w_enable)     w_fbusy_d[reg_w_dest] = 1'b0;
    if (w_fire && r_wr_x)  w_xbusy_d[r_rd]       = 1'b1;
    if (w_fire && r_wr_f)  w_fbusy_d[r_rd]       = 1'b1;
    w_xbusy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_xbusy <= '0;
      r_fbusy <= '0;
      r_src_f <= '0;
      r_uses  <= '0;
      r_rd    <= '0;
      r_wr_x  <= 1'b0;
      r_wr_f  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        r_xreg[i] <= '0;
        r_freg[i] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        r_src[k]  <= '0;
        r_data[k] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      r_xbusy <= w_xbusy_d;
      r_fbusy <= w_fbusy_d;
      if (w_x_wr)        r_xreg[reg_w_dest] <= reg_w_data;
      if (freg_w_enable) r_freg[reg_w_dest] <= reg_w_data;
      if (r_state == StIdle && enabled) begin
        r_src[0] <= rs1;
        r_src[1] <= rs2;
        r_src[2] <= rs3;
        r_src_f  <= {1'b1, rs2_is_f, rs1_is_f};
        r_uses   <= {uses_rs3, uses_rs2, uses_rs1};
        r_rd     <= rd;
        r_wr_x   <= writes_to_reg;
        r_wr_f   <= writes_to_freg;
        r_done   <= 1'b0;
      end
      if (w_fire) begin
        for (int k = 0; k < 3; k++) r_data[k] <= w_val[k];
        r_done <= 1'b1;
      end
    end
  end

  assign rs1_data  = r_data[0];
  assign rs2_data  = r_data[1];
  assign rs3_data  = r_data[2];
  assign completed = r_done & ~enabled;

endmodule

// File: tb/tb_reg_read.sv
// Directed, scoreboard-based bench for reg_read; expected latency of RAW stalls follows
// whether REG_READ_BYPASS_EN is defined.
module tb_reg_read;

  logic        clk = 1'b0;
  logic        rst;
  logic        enabled;
  logic [4:0]  rs1, rs2, rs3, rd, reg_w_dest;
  logic        rs1_is_f, rs2_is_f;
  logic        uses_rs1, uses_rs2, uses_rs3;
  logic        writes_to_reg, writes_to_freg;
  logic        reg_w_enable, freg_w_enable;
  logic [31:0] reg_w_data;
  logic [31:0] rs1_data, rs2_data, rs3_data;
  logic        completed;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] d3;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last1 = '0;

`ifdef REG_READ_BYPASS_EN
  localparam int RawLat = 1;
`else
  localparam int RawLat = 2;
`endif

  always #5 clk = ~clk;

  reg_read dut (
    .clk           (clk),
    .rst           (rst),
    .enabled       (enabled),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_is_f      (rs1_is_f),
    .rs2_is_f      (rs2_is_f),
    .rs3           (rs3),
    .uses_rs1      (uses_rs1),
    .uses_rs2      (uses_rs2),
    .uses_rs3      (uses_rs3),
    .rd            (rd),
    .writes_to_reg (writes_to_reg),
    .writes_to_freg(writes_to_freg),
    .reg_w_enable  (reg_w_enable),
    .freg_w_enable (freg_w_enable),
    .reg_w_dest    (reg_w_dest),
    .reg_w_data    (reg_w_data),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .rs3_data      (rs3_data),
    .completed     (completed)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One-cycle write-back pulse starting at the current falling edge.
  task automatic wr(input logic x, input logic f, input logic [4:0] d, input logic [31:0] v);
    reg_w_enable  = x;
    freg_w_enable = f;
    reg_w_dest    = d;
    reg_w_data    = v;
    @(negedge clk);
    reg_w_enable  = 1'b0;
    freg_w_enable = 1'b0;
  endtask

  task automatic issue(input logic [4:0] a, input logic af, input logic [4:0] b, input logic bf,
                       input logic [4:0] c, input logic [2:0] u, input logic [4:0] d,
                       input logic wx, input logic wf, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3, input int lat);
    exp_t e;
    rs1 = a; rs1_is_f = af; rs2 = b; rs2_is_f = bf; rs3 = c;
    uses_rs1 = u[0]; uses_rs2 = u[1]; uses_rs3 = u[2];
    rd = d; writes_to_reg = wx; writes_to_freg = wf;
    enabled = 1'b1;
    e.d1 = e1; e.d2 = e2; e.d3 = e3; e.lat = lat;
    sb.push_back(e);
    #1 chk("completed_drops", {31'b0, completed}, 32'd0);
    @(negedge clk);
    enabled = 1'b0;
    writes_to_reg = 1'b0;
    writes_to_freg = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   n = 0;
    do begin
      @(negedge clk);
      reg_w_enable  = 1'b0;
      freg_w_enable = 1'b0;
      n++;
    end while (!completed && n < 20);
    chk({tag, "_sb"}, sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_done"}, {31'b0, completed}, 32'd1);
      chk({tag, "_lat"}, n, e.lat);
      chk({tag, "_rs1"}, rs1_data, e.d1);
      chk({tag, "_rs2"}, rs2_data, e.d2);
      chk({tag, "_rs3"}, rs3_data, e.d3);
      last1 = e.d1;
    end
  endtask

  task automatic stall(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      chk({tag, "_stall"}, {31'b0, completed}, 32'd0);
      chk({tag, "_hold"}, rs1_data, last1);
    end
  endtask

  initial begin
    rst = 1'b1; enabled = 1'b0;
    rs1 = '0; rs2 = '0; rs3 = '0; rd = '0; reg_w_dest = '0; reg_w_data = '0;
    rs1_is_f = 1'b0; rs2_is_f = 1'b0;
    uses_rs1 = 1'b0; uses_rs2 = 1'b0; uses_rs3 = 1'b0;
    writes_to_reg = 1'b0; writes_to_freg = 1'b0;
    reg_w_enable = 1'b0; freg_w_enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_completed", {31'b0, completed}, 32'd0);
    chk("reset_rs1", rs1_data, 32'd0);
    chk("reset_rs2", rs2_data, 32'd0);
    chk("reset_rs3", rs3_data, 32'd0);
    rst = 1'b0;

    // Basic read of x5 and x0
    wr(1'b1, 1'b0, 5'd5, 32'h1234_5678);
    issue(5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 3'b111, 5'd0, 1'b0, 1'b0,
          32'h1234_5678, 32'd0, 32'd0, 1);
    wait_done("t1_x5_x0");

    // RAW stall on reserved x7
    issue(5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 5'd7, 1'b1, 1'b0,
          32'h1234_5678, 32'd0, 32'd0, 1);
    wait_done("t2_reserve_x7");
    issue(5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 3'b001, 5'd0, 1'b0, 1'b0,
          32'hDEAD_BEEF, 32'd0, 32'd0, RawLat);
    stall(3, "t2");
    reg_w_enable = 1'b1; reg_w_dest = 5'd7; reg_w_data = 32'hDEAD_BEEF;
    wait_done("t2_raw_x7");

    // Float bank vs same-index integer register
    wr(1'b0, 1'b1, 5'd3, 32'h3F80_0000);
    wr(1'b1, 1'b0, 5'd3, 32'h0000_0011);
    issue(5'd3, 1'b0, 5'd3, 1'b1, 5'd3, 3'b111, 5'd0, 1'b0, 1'b0,
          32'h0000_0011, 32'h3F80_0000, 32'h3F80_0000, 1);
    wait_done("t3_float");

    // x0 hardwired and never reserved
    wr(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF);
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b001, 5'd0, 1'b1, 1'b0,
          32'd0, 32'd0, 32'd0, 1);
    wait_done("t4_x0_rd0");
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b001, 5'd0, 1'b0, 1'b0,
          32'd0, 32'd0, 32'd0, 1);
    wait_done("t4_x0_nostall");

    // Reserve f9 in the same cycle its write-back clears it
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 5'd9, 1'b0, 1'b1,
          32'd0, 32'd0, 32'd0, 1);
    freg_w_enable = 1'b1; reg_w_dest = 5'd9; reg_w_data = 32'hAAAA_0000;
    wait_done("t5_reserve_f9");
    issue(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 3'b001, 5'd0, 1'b0, 1'b0,
          32'h0000_0055, 32'd0, 32'd0, RawLat);
    stall(3, "t5");
    freg_w_enable = 1'b1; reg_w_dest = 5'd9; reg_w_data = 32'h0000_0055;
    wait_done("t5_raw_f9");

    // Reset while stalled in WAIT
    issue(5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 5'd10, 1'b1, 1'b0,
          32'h1234_5678, 32'd0, 32'd0, 1);
    wait_done("t6_reserve_x10");
    issue(5'd10, 1'b0, 5'd5, 1'b0, 5'd0, 3'b001, 5'd0, 1'b0, 1'b0,
          32'd0, 32'd0, 32'd0, 1);
    stall(2, "t6");
    rst = 1'b1;
    #1;
    chk("t6_rst_completed", {31'b0, completed}, 32'd0);
    chk("t6_rst_rs1", rs1_data, 32'd0);
    chk("t6_rst_rs2", rs2_data, 32'd0);
    chk("t6_rst_rs3", rs3_data, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(5'd10, 1'b0, 5'd5, 1'b0, 5'd0, 3'b011, 5'd0, 1'b0, 1'b0,
          32'd0, 32'd0, 32'd0, 1);
    wait_done("t6_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
